// File: rtl/uart_rx_core_pkg.sv
// Shared definitions for the UART receive path: FSM encoding, frame shape,
// and the baud divider formula used to size the bit-timing counter.
package uart_rx_core_pkg;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } rx_state_e;

    // Clocks per bit, integer division (25 MHz / 9600 -> 2604).
    function automatic int baud_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_core_sync.sv
// Two-flop synchronizer for the asynchronous rx pin plus falling-edge detect.
// All flops reset to 1 so a reset never looks like a start edge on an idle line.
module uart_rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Next values: shift the pin through the chain, keep one old copy for the edge.
    always_comb begin
        meta_d = rx_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    // Synchronizer and edge-history flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            prev_q <= 1'b1;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rx_s    = sync_q;
    assign rx_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 RS232 receiver with mid-bit sampling. rx_int brackets a frame and falls
// in the same cycle rx_data is updated, so downstream can key off that edge.
// state_dbg exposes the FSM state for observation only.
import uart_rx_core_pkg::*;

module uart_rx_core #(
    parameter int CLK_FREQ = 25_000_000,
    parameter int BAUD     = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs232_rx,
    output logic [7:0] rx_data,
    output logic       rx_int,
    output logic       data_valid,
    output logic       frame_err,
    output logic [1:0] state_dbg
);

    localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
    localparam int DIV_W    = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(BAUD_DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(BAUD_DIV - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    logic rx_s;
    logic rx_fall;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .rx_in   (rs232_rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall)
    );

    rx_state_e        state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_int_q, rx_int_d;
    logic             dv_q, dv_d;
    logic             fe_q, fe_d;

    // Next-state: edges inside a frame are ignored because only IDLE looks at rx_fall.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        rx_data_d = rx_data_q;
        rx_int_d  = rx_int_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_fall) begin
                    state_d  = ST_START;
                    div_d    = '0;
                    rx_int_d = 1'b1;
                end
            end
            ST_START: begin
                if (div_q == HALF_LAST) begin
                    div_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        bit_d   = 3'd0;
                    end else begin
                        // Line back high by mid-start: a glitch, not a frame.
                        state_d  = ST_IDLE;
                        rx_int_d = 1'b0;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (div_q == FULL_LAST) begin
                    div_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    if (bit_q == LAST_BIT) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (div_q == FULL_LAST) begin
                    div_d    = '0;
                    rx_int_d = 1'b0;
                    state_d  = ST_IDLE;
                    if (rx_s) begin
                        rx_data_d = shift_q;
                        dv_d      = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            bit_q     <= 3'd0;
            shift_q   <= 8'd0;
            rx_data_q <= 8'd0;
            rx_int_q  <= 1'b0;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            rx_data_q <= rx_data_d;
            rx_int_q  <= rx_int_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_int     = rx_int_q;
    assign data_valid = dv_q;
    assign frame_err  = fe_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core with CLK_FREQ=160, BAUD=10 (16 clk per bit).
`timescale 1ns/1ps

module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rs232_rx = 1'b1;
    logic [7:0] rx_data;
    logic       rx_int;
    logic       data_valid;
    logic       frame_err;
    logic [1:0] state_dbg;

    int errors = 0;
    int checks = 0;

    // Monitor counters.
    int rise_cnt = 0, fall_cnt = 0, dv_cnt = 0, fe_cnt = 0, dv_fall_cnt = 0;
    int int_len = 0, last_len = 0;
    logic int_prev = 1'b0;
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];

    // Snapshots taken at the start of each step.
    int b_rise, b_fall, b_dv, b_fe, b_dvf;

    uart_rx_core #(.CLK_FREQ(160), .BAUD(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .rs232_rx   (rs232_rx),
        .rx_data    (rx_data),
        .rx_int     (rx_int),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .state_dbg  (state_dbg)
    );

    // Clock and watchdog.
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    // Output monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (rx_int && !int_prev) begin
                rise_cnt++;
                int_len = 0;
            end
            if (rx_int) int_len++;
            if (!rx_int && int_prev) begin
                fall_cnt++;
                last_len = int_len;
                if (data_valid) dv_fall_cnt++;
            end
            if (data_valid) begin
                dv_cnt++;
                got_q.push_back(rx_data);
            end
            if (frame_err) fe_cnt++;
        end
        int_prev = rx_int;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one frame; bit length is l100/100 clk, accumulated so fractional skew is exact.
    task automatic send_frame(input logic [7:0] d, input logic stop, input int l100);
        logic [9:0] bits;
        bits = {stop, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            rs232_rx = bits[k];
            tick(((k + 1) * l100 + 50) / 100 - (k * l100 + 50) / 100);
        end
    endtask

    task automatic snap();
        b_rise = rise_cnt;
        b_fall = fall_cnt;
        b_dv   = dv_cnt;
        b_fe   = fe_cnt;
        b_dvf  = dv_fall_cnt;
    endtask

    // Scoreboard: every expected byte must have been received in order, nothing extra.
    task automatic check_bytes(input string tag);
        logic [7:0] e;
        logic [7:0] g;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (got_q.size() > 0) begin
                g = got_q.pop_front();
                check(tag, 32'(g), 32'(e));
            end else begin
                check({tag, "_missing"}, 32'(got_q.size()), 32'd1);
            end
        end
        check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    initial begin
        logic [7:0] d;

        // Reset state.
        tick(3);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_int", 32'(rx_int), 32'd0);
        check("rst_dv", 32'(data_valid), 32'd0);
        check("rst_fe", 32'(frame_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);
        rst = 1'b0;
        tick(10);

        // 1: single 0x55 frame.
        snap();
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b1, 1600);
        tick(30);
        check("t1_dv_cnt", 32'(dv_cnt - b_dv), 32'd1);
        check("t1_fe_cnt", 32'(fe_cnt - b_fe), 32'd0);
        check("t1_falls", 32'(fall_cnt - b_fall), 32'd1);
        check("t1_int_len", 32'(last_len), 32'd152);
        check("t1_dv_at_fall", 32'(dv_fall_cnt - b_dvf), 32'd1);
        check("t1_rx_data", 32'(rx_data), 32'h55);
        check("t1_state", 32'(state_dbg), 32'd0);
        check_bytes("t1_byte");

        // 2: back-to-back 0xA3, 0x0F.
        snap();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        send_frame(8'hA3, 1'b1, 1600);
        send_frame(8'h0F, 1'b1, 1600);
        tick(30);
        check("t2_dv_cnt", 32'(dv_cnt - b_dv), 32'd2);
        check("t2_falls", 32'(fall_cnt - b_fall), 32'd2);
        check("t2_dv_at_fall", 32'(dv_fall_cnt - b_dvf), 32'd2);
        check("t2_fe_cnt", 32'(fe_cnt - b_fe), 32'd0);
        check("t2_rx_data", 32'(rx_data), 32'h0F);
        check_bytes("t2_byte");

        // 3: 5-clk low glitch on an idle line.
        snap();
        rs232_rx = 1'b0;
        tick(5);
        rs232_rx = 1'b1;
        tick(30);
        check("t3_rises", 32'(rise_cnt - b_rise), 32'd1);
        check("t3_falls", 32'(fall_cnt - b_fall), 32'd1);
        check("t3_int_len", 32'(last_len), 32'd8);
        check("t3_dv_cnt", 32'(dv_cnt - b_dv), 32'd0);
        check("t3_fe_cnt", 32'(fe_cnt - b_fe), 32'd0);
        check("t3_rx_data", 32'(rx_data), 32'h0F);

        // 4: 0x81 with low stop bit, then line held low (break) before returning high.
        snap();
        send_frame(8'h81, 1'b0, 1600);
        tick(200);
        rs232_rx = 1'b1;
        tick(30);
        check("t4_fe_cnt", 32'(fe_cnt - b_fe), 32'd1);
        check("t4_dv_cnt", 32'(dv_cnt - b_dv), 32'd0);
        check("t4_rises", 32'(rise_cnt - b_rise), 32'd1);
        check("t4_falls", 32'(fall_cnt - b_fall), 32'd1);
        check("t4_rx_data", 32'(rx_data), 32'h0F);
        check_bytes("t4_byte");

        // 5: reset in bit 4 of 0xC6, then 0x3C.
        snap();
        d = 8'hC6;
        rs232_rx = 1'b0;
        tick(16);
        for (int i = 0; i < 4; i++) begin
            rs232_rx = d[i];
            tick(16);
        end
        rs232_rx = d[4];
        tick(8);
        check("t5_pre_int", 32'(rx_int), 32'd1);
        rst = 1'b1;
        #1;
        check("t5_rst_rx_data", 32'(rx_data), 32'h00);
        check("t5_rst_rx_int", 32'(rx_int), 32'd0);
        check("t5_rst_state", 32'(state_dbg), 32'd0);
        rs232_rx = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(20);
        check("t5_no_dv", 32'(dv_cnt - b_dv), 32'd0);
        check("t5_no_fe", 32'(fe_cnt - b_fe), 32'd0);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1600);
        tick(30);
        check("t5_dv_cnt", 32'(dv_cnt - b_dv), 32'd1);
        check("t5_rx_data", 32'(rx_data), 32'h3C);
        check_bytes("t5_byte");

        // 6: 0x99 with bit time 4% short, then 4% long.
        snap();
        exp_q.push_back(8'h99);
        exp_q.push_back(8'h99);
        send_frame(8'h99, 1'b1, 1536);
        tick(30);
        send_frame(8'h99, 1'b1, 1664);
        tick(30);
        check("t6_dv_cnt", 32'(dv_cnt - b_dv), 32'd2);
        check("t6_fe_cnt", 32'(fe_cnt - b_fe), 32'd0);
        check("t6_rx_data", 32'(rx_data), 32'h99);
        check_bytes("t6_byte");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
